pll_reset_sequencer: RTL and testbench

Sequences the rPLL after power-up and after any loss of lock. It pulses the PLL RESET input, waits for LOCK with a timeout and retry, and qualifies lock stability over a programmable window. It then releases the system reset for logic clocked by the PLL output. It runs on the free-running 27 MHz board clock, never on the PLL output, so it keeps working while the PLL is unlocked.

---
 rtl/pll_reset_sequencer_if.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 140 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Status/control bundle between the PLL reset sequencer and its surroundings.
interface pll_reset_sequencer_if #(
    parameter int unsigned STAT_WIDTH = 4
);
    logic                  locked;
    logic                  relock_req;
    logic                  pll_reset;
    logic                  sys_reset_n;
    logic                  ready;
    logic [1:0]            state;
    logic [STAT_WIDTH-1:0] retries;
    logic [STAT_WIDTH-1:0] lock_losses;

    // Sequencer side
    modport master (
        input  locked, relock_req,
        output pll_reset, sys_reset_n, ready, state, retries, lock_losses
    );

    // PLL / system side
    modport slave (
        output locked, relock_req,
        input  pll_reset, sys_reset_n, ready, state, retries, lock_losses
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL reset, waits for lock with timeout/retry,
// qualifies lock stability, then releases the system reset. Runs on the
// free-running board clock so it keeps working while the PLL is unlocked.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned CNT_WIDTH      = 17,
    parameter int unsigned STAT_WIDTH     = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    pll_reset_sequencer_if.master     bus
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0]  RST_LAST     = CNT_WIDTH'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0]  STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX     = '1;

    logic                  locked_meta;
    logic                  locked_s;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [STAT_WIDTH-1:0] retries_q, retries_d;
    logic [STAT_WIDTH-1:0] lock_losses_q, lock_losses_d;
    logic                  pll_reset_q, pll_reset_d;
    logic                  run_q, run_d;

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= bus.locked;
            locked_s    <= locked_meta;
        end
    end

    // Next-state, shared counter, statistics and next-output decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        retries_d     = retries_q;
        lock_losses_d = lock_losses_q;

        if (bus.relock_req) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = RESET_PLL;
                        cnt_d   = '0;
                        if (retries_q != STAT_MAX) begin
                            retries_d = retries_q + STAT_WIDTH'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d = RESET_PLL;
                        cnt_d   = '0;
                        if (lock_losses_q != STAT_MAX) begin
                            lock_losses_d = lock_losses_q + STAT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end

        pll_reset_d = (state_d == RESET_PLL);
        run_d       = (state_d == RUN);
    end

    // State, counter, statistics and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RESET_PLL;
            cnt_q         <= '0;
            retries_q     <= '0;
            lock_losses_q <= '0;
            pll_reset_q   <= 1'b1;
            run_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retries_q     <= retries_d;
            lock_losses_q <= lock_losses_d;
            pll_reset_q   <= pll_reset_d;
            run_q         <= run_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.pll_reset   = pll_reset_q;
    assign bus.sys_reset_n = run_q;
    assign bus.ready       = run_q;
    assign bus.retries     = retries_q;
    assign bus.lock_losses = lock_losses_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: phase/elapsed-time reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_pll_reset_sequencer;

    localparam int unsigned P_RST  = 4;
    localparam int unsigned P_TO   = 20;
    localparam int unsigned P_ST   = 8;
    localparam int unsigned P_CW   = 17;
    localparam int unsigned P_SW   = 2;
    localparam int          SATMAX = 3;

    logic clock = 1'b0;
    logic reset_n;

    pll_reset_sequencer_if #(.STAT_WIDTH(P_SW)) bus ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (P_RST),
        .LOCK_TIMEOUT   (P_TO),
        .STABLE_CYCLES  (P_ST),
        .CNT_WIDTH      (P_CW),
        .STAT_WIDTH     (P_SW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference: phase 0..3 (reset pulse, await lock, stability, run) and
    // time spent in the current phase; lock seen through a 2-deep delay line.
    typedef struct packed {
        int   phase;
        int   elapsed;
        logic s1;
        logic s2;
        int   retr;
        int   loss;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t cur, logic lk, logic rq);
        model_t n;
        n         = cur;
        n.s1      = lk;
        n.s2      = cur.s1;
        n.elapsed = cur.elapsed + 1;
        if (rq) begin
            n.phase   = 0;
            n.elapsed = 0;
        end else if (cur.phase == 0) begin
            if (n.elapsed == int'(P_RST)) begin
                n.phase   = 1;
                n.elapsed = 0;
            end
        end else if (cur.phase == 1) begin
            if (cur.s2) begin
                n.phase   = 2;
                n.elapsed = 0;
            end else if (n.elapsed == int'(P_TO)) begin
                n.phase   = 0;
                n.elapsed = 0;
                n.retr    = (cur.retr < SATMAX) ? cur.retr + 1 : cur.retr;
            end
        end else if (cur.phase == 2) begin
            if (!cur.s2) begin
                n.phase   = 1;
                n.elapsed = 0;
            end else if (n.elapsed == int'(P_ST)) begin
                n.phase   = 3;
                n.elapsed = 0;
            end
        end else begin
            if (!cur.s2) begin
                n.phase   = 0;
                n.elapsed = 0;
                n.loss    = (cur.loss < SATMAX) ? cur.loss + 1 : cur.loss;
            end
        end
        return n;
    endfunction

    // Model advances on the same edges as the DUT
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else          m <= model_next(m, bus.locked, bus.relock_req);
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clock) begin
        logic [1:0] e_state;
        logic       e_prst, e_run;
        e_state = 2'(m.phase);
        e_prst  = (m.phase == 0);
        e_run   = (m.phase == 3);
        vectors++;
        if (bus.state !== e_state || bus.pll_reset !== e_prst ||
            bus.sys_reset_n !== e_run || bus.ready !== e_run ||
            bus.retries !== 2'(m.retr) || bus.lock_losses !== 2'(m.loss)) begin
            miscompares++;
            $display("FAIL model t=%0t: state=%0d/%0d pll_reset=%0b/%0b sys_reset_n=%0b/%0b ready=%0b/%0b retries=%0d/%0d lock_losses=%0d/%0d (got/expected)",
                     $time, bus.state, e_state, bus.pll_reset, e_prst,
                     bus.sys_reset_n, e_run, bus.ready, e_run,
                     bus.retries, m.retr, bus.lock_losses, m.loss);
        end
    end

    task automatic lit(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int bound, input string nm);
        int i;
        i = 0;
        while (bus.state !== s && i < bound) begin
            tick();
            i++;
        end
        vectors++;
        if (bus.state !== s) begin
            miscompares++;
            $display("FAIL %s: timeout, state got %0d expected %0d", nm, bus.state, s);
        end
    endtask

    // Edges until sys_reset_n rises (bounded)
    task automatic edges_to_release(input int bound, output int n);
        n = 0;
        while (bus.sys_reset_n !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int fall, n, hold;
        bus.locked     = 1'b0;
        bus.relock_req = 1'b0;
        reset_n        = 1'b1;
        #1 reset_n     = 1'b0;

        // Reset values
        tick(); tick(); tick();
        lit("reset_state", int'(bus.state), 0);
        lit("reset_pll_reset", int'(bus.pll_reset), 1);
        lit("reset_sys_reset_n", int'(bus.sys_reset_n), 0);
        lit("reset_ready", int'(bus.ready), 0);

        // Cold start: lock rises 10 cycles after release
        reset_n = 1'b1;
        fall = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.pll_reset === 1'b0 && fall == 0) fall = i;
        end
        lit("cold_pll_reset_fall_edge", fall, 4);
        bus.locked = 1'b1;
        edges_to_release(60, n);
        lit("cold_release_edges", n, 11);
        lit("cold_ready", int'(bus.ready), 1);
        lit("cold_retries", int'(bus.retries), 0);

        // Lock drop in RUN
        bus.locked = 1'b0;
        n = 0;
        while (!(bus.sys_reset_n === 1'b0 && bus.pll_reset === 1'b1) && n < 10) begin
            tick();
            n++;
        end
        lit("loss_reaction_edges", n, 3);
        lit("loss_count", int'(bus.lock_losses), 1);
        repeat (6) tick();
        bus.locked = 1'b1;
        wait_state(2'd3, 100, "loss_resequence");

        // Relock in RUN, then again at cnt=2 of the reset pulse
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        lit("relock_state", int'(bus.state), 0);
        lit("relock_pll_reset", int'(bus.pll_reset), 1);
        tick(); tick();
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        n = 0;
        while (bus.pll_reset === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        lit("relock_restart_edges", n, 4);
        lit("relock_losses_unchanged", int'(bus.lock_losses), 1);
        wait_state(2'd3, 100, "relock_resequence");

        // Glitch during STABLE at count 5
        bus.locked     = 1'b0;
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        wait_state(2'd1, 20, "glitch_wait_lock");
        bus.locked = 1'b1;
        wait_state(2'd2, 20, "glitch_stable");
        repeat (5) tick();
        bus.locked = 1'b0;
        tick(); tick(); tick();
        lit("glitch_back_to_wait", int'(bus.state), 1);
        bus.locked = 1'b1;
        edges_to_release(60, n);
        lit("glitch_release_edges", n, 11);
        lit("glitch_retries", int'(bus.retries), 0);
        lit("glitch_losses", int'(bus.lock_losses), 1);

        // Async reset during STABLE
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        wait_state(2'd2, 20, "rst_reach_stable");
        #2 reset_n = 1'b0;
        #1;
        lit("async_state", int'(bus.state), 0);
        lit("async_pll_reset", int'(bus.pll_reset), 1);
        lit("async_sys_reset_n", int'(bus.sys_reset_n), 0);
        lit("async_ready", int'(bus.ready), 0);
        lit("async_losses", int'(bus.lock_losses), 0);
        bus.locked = 1'b0;
        tick(); tick();

        // Lock held low: retries 1,2,3,3 every 24 cycles
        reset_n = 1'b1;
        for (int i = 1; i <= 96; i++) begin
            tick();
            if (i == 23) lit("to_retries_23", int'(bus.retries), 0);
            if (i == 24) lit("to_retries_24", int'(bus.retries), 1);
            if (i == 24) lit("to_pll_reset_24", int'(bus.pll_reset), 1);
            if (i == 27) lit("to_pll_reset_27", int'(bus.pll_reset), 1);
            if (i == 28) lit("to_pll_reset_28", int'(bus.pll_reset), 0);
            if (i == 48) lit("to_retries_48", int'(bus.retries), 2);
            if (i == 72) lit("to_retries_72", int'(bus.retries), 3);
            if (i == 96) lit("to_retries_96", int'(bus.retries), 3);
        end

        // Relock coinciding with lock drop in RUN: no loss counted
        bus.locked = 1'b1;
        wait_state(2'd3, 100, "coincide_run");
        bus.locked = 1'b0;
        tick(); tick();
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        lit("coincide_state", int'(bus.state), 0);
        lit("coincide_losses", int'(bus.lock_losses), 0);

        // Randomized lock behaviour and relock requests
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (hold == 0) begin
                bus.locked = ($urandom_range(0, 3) != 0);
                hold = int'($urandom_range(1, 60));
            end else begin
                hold--;
            end
            bus.relock_req = ($urandom_range(0, 49) == 0);
        end
        bus.relock_req = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
